// File: rtl/axi_slave2_wr_arbiter.sv
// axi_slave2_wr_arbiter: round-robin arbiter sharing the Slave 2 AW/W/B handshakes among NUM_M masters.
// A grant covers one whole write transaction; the payload mux outside follows grant_idx.
module axi_slave2_wr_arbiter #(
  parameter int NUM_M = 4,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_4000,
  parameter logic [ADDR_W-1:0] END_ADDR = 32'h0000_4FFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_M-1:0]          m_awvalid,
  input  logic [NUM_M*ADDR_W-1:0]   m_awaddr,
  output logic [NUM_M-1:0]          m_awready,
  input  logic [NUM_M-1:0]          m_wvalid,
  input  logic [NUM_M-1:0]          m_wlast,
  output logic [NUM_M-1:0]          m_wready,
  output logic [NUM_M-1:0]          m_bvalid,
  input  logic [NUM_M-1:0]          m_bready,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic                      s_wvalid,
  output logic                      s_wlast,
  input  logic                      s_wready,
  input  logic                      s_bvalid,
  output logic                      s_bready,
  output logic [NUM_M-1:0]          grant,
  output logic [$clog2(NUM_M)-1:0]  grant_idx,
  output logic                      busy,
  output logic [7:0]                oor_cnt
);
  localparam int IW = $clog2(NUM_M);
  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] rr_last, pick;
  logic pick_ok;
  logic [NUM_M-1:0] eligible, oor, oor_q;
  logic [8:0] oor_sum;
  int best_d;
  for (genvar i = 0; i < NUM_M; i++) begin : g_el
    logic [ADDR_W-1:0] a;
    assign a = m_awaddr[i*ADDR_W +: ADDR_W];
    assign oor[i] = m_awvalid[i] && (a < BASE_ADDR || a > END_ADDR);
    assign eligible[i] = m_awvalid[i] && !oor[i];
  end
  // Winner is the eligible master at the smallest distance after rr_last.
  always_comb begin
    pick = '0;
    pick_ok = 1'b0;
    best_d = NUM_M;
    for (int i = 0; i < NUM_M; i++)
      if (eligible[i] && (i + NUM_M - 1 - int'(rr_last)) % NUM_M < best_d) begin
        best_d = (i + NUM_M - 1 - int'(rr_last)) % NUM_M;
        pick = IW'(i);
        pick_ok = 1'b1;
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (pick_ok ? AW : IDLE)
              : state == AW   ? (s_awvalid && s_awready ? W : AW)
              : state == W    ? (s_wvalid && s_wready && s_wlast ? B : W)
              :                 (s_bvalid && s_bready ? IDLE : B);
  always_comb begin
    s_awvalid = state == AW && m_awvalid[grant_idx];
    s_wvalid = state == W && m_wvalid[grant_idx];
    s_wlast = state == W && m_wlast[grant_idx];
    s_bready = state == B && m_bready[grant_idx];
    m_awready = state == AW && s_awready ? grant : '0;
    m_wready = state == W && s_wready ? grant : '0;
    m_bvalid = state == B && s_bvalid ? grant : '0;
    busy = state != IDLE;
  end
  // Each master's out-of-range condition is counted once per rising edge.
  assign oor_sum = 9'(oor_cnt) + 9'($countones(oor & ~oor_q));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      grant <= '0;
      grant_idx <= '0;
      rr_last <= IW'(NUM_M - 1);
      oor_q <= '0;
      oor_cnt <= '0;
    end else begin
      oor_q <= oor;
      oor_cnt <= oor_sum > 9'd255 ? 8'hFF : oor_sum[7:0];
      if (state == IDLE && pick_ok) begin
        grant <= NUM_M'(1) << pick;
        grant_idx <= pick;
      end else if (state == B && s_bvalid && s_bready) begin
        grant <= '0;
        grant_idx <= '0;
        rr_last <= grant_idx;
      end
    end
endmodule
